ws2812_chain_driver: RTL and testbench
======================================

Name: ws2812_chain_driver

Overview:
Parametrised WS2812/SK6812 serial LED chain driver. It holds a frame buffer of NUM_LEDS pixels written through a simple write port. On a start request it streams the whole chain MSB-first with programmable bit timing and applies a global brightness scale. It then holds the line low for the latch gap and signals completion. It sits between the colour/effect logic (pattern generators, button handlers) and the single LED data pin.

Parameters:
CLK_FREQ, 10000000, clock frequency in Hz; documentation only, timing is in cycles
NUM_LEDS, 8, number of pixels in the chain (>=1)
CHANNELS, 3, bytes per pixel: 3 = GRB (WS2812), 4 = GRBW (SK6812)
T0H, 4, high cycles for a '0' bit
T0L, 8, low cycles for a '0' bit
T1H, 7, high cycles for a '1' bit
T1L, 6, low cycles for a '1' bit
RES, 500, low cycles of the latch/reset gap after the last bit

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  frame buffer write strobe
wr_addr  in  AW=max(1,$clog2(NUM_LEDS))  pixel index
wr_data  in  8*CHANNELS  pixel word; first-sent byte in MSBs
brightness  in  8  global scale; 255 = full
start  in  1  request a frame transmission
busy  out  1  high from start accept until done
done  out  1  one-cycle pulse at end of latch gap
ws_out  out  1  registered serial data to LED chain

Behaviour:
- Reset (synchronous, rst=1 at clk edge): ws_out=0, busy=0, done=0, FSM=IDLE, all counters cleared. Frame buffer contents are not reset.
- Writes: wr_en=1 with wr_addr<NUM_LEDS stores wr_data at the next edge, in any state. Writes with wr_addr>=NUM_LEDS are ignored.
- Pixel fetch: each pixel is read from the buffer when it is fetched. A same-cycle write to the address being fetched yields the old data.
- Brightness: sampled at start accept and held for the whole frame. Each byte is scaled as b' = (b*(brightness+1))>>8 (16-bit product, upper byte kept). brightness=255 passes data unchanged; brightness=0 sends all zeros.
- FSM states: IDLE, LOAD, HIGH, LOW, LATCH.
  - IDLE: ws_out=0. If start=1, go to LOAD and set busy=1.
  - start while busy=1 is ignored, with no queueing.
  - rst and start in the same cycle: reset wins.
- LOAD (1 cycle): fetch pixel 0, scale it into the shift register, set bit_cnt=0 and pix_cnt=0. Next state is HIGH.
- HIGH: ws_out=1 for T1H cycles if the current MSB is 1, otherwise T0H cycles. Then go to LOW.
- LOW: ws_out=0 for T1L cycles (bit=1) or T0L cycles (bit=0). Then:
  - more bits remain in the pixel: shift left and go to HIGH;
  - last bit of pixel, pix_cnt<NUM_LEDS-1: load the next pixel, which was prefetched during this bit, and go to HIGH with no extra cycle;
  - last bit of last pixel: go to LATCH.
- Bit periods are exact, including pixel boundaries: no dead cycles between bits.
- LATCH: ws_out=0 for RES cycles. At the last LATCH cycle's edge, go to IDLE, set busy=0 and pulse done=1 for one cycle.
  - A start in that same cycle is ignored.
  - A start in the following cycle is accepted.
- Timing: first rising edge of ws_out is 2 edges after the start-accept edge (accept edge, then LOAD edge).
- Frame length from accept to done: 1 + sum of bit periods + RES cycles.
- Reset mid-frame: ws_out drops to 0 next edge and busy=0, with no done pulse. The chain sees a truncated frame, which the next full frame overwrites.
- Widths: the bit counter counts 0..8*CHANNELS-1; pix_cnt counts 0..NUM_LEDS-1; the timing counter is wide enough for max(RES, T*H, T*L).

Test Plan:
- Reset then idle: after rst, with no start for 100 cycles -> ws_out=0, busy=0, done never asserted.
- NUM_LEDS=2, CHANNELS=3, write 0x000000 to both pixels, brightness=255, start:
  - 48 pulses, each 4 cycles high and 8 low;
  - busy high for 1+576+500=1077 cycles, then a one-cycle done.
- Write pixel0=0xFF00AA, pixel1=0x800080, brightness=255:
  - decoded bitstream equals FF00AA800080 MSB-first;
  - '1' pulses are 7 high/6 low;
  - no gap cycles at the pixel boundary.
- Brightness=127 with pixel 0xFF8001 -> transmitted 0x7F4000.
- start during busy, plus a write to pixel 1 while pixel 0 is being sent:
  - the extra start is ignored (a single done);
  - pixel 1 is sent with the new data;
  - a write with wr_addr=NUM_LEDS leaves the buffer unchanged.
- Assert rst mid-pixel 1 -> ws_out=0 and busy=0 at the next edge, no done. A new start afterwards gives a full, correct frame.

Source files
------------

// File: rtl/ws2812_chain_driver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ws2812_chain_driver
//
// Streams a frame buffer of NUM_LEDS pixels to a WS2812 (GRB) or SK6812
// (GRBW) LED chain over one data pin. Each pixel is sent MSB-first as
// 8*CHANNELS bits. Every bit is one high phase followed by one low phase, and
// the phase lengths depend on the bit value. A global brightness scale is
// applied as each pixel is loaded. After the last bit the line is held low for
// RES cycles so that the chain latches, and then done pulses.
//
// Ports
//   clk         system clock (all timing is counted in cycles of clk)
//   rst         synchronous, active-high reset
//   wr_en       frame buffer write strobe
//   wr_addr     pixel index; writes at or beyond NUM_LEDS are dropped
//   wr_data     pixel word; the first byte sent is in the MSBs
//   brightness  global scale, sampled when a frame starts; 255 = full
//   start       request one frame; ignored while busy
//   busy        high from start accept until done
//   done        one-cycle pulse at the end of the latch gap
//   ws_out      registered serial data to the LED chain
// ---------------------------------------------------------------------------
module ws2812_chain_driver #(
    parameter int CLK_FREQ = 10000000,
    parameter int NUM_LEDS = 8,
    parameter int CHANNELS = 3,
    parameter int T0H      = 4,
    parameter int T0L      = 8,
    parameter int T1H      = 7,
    parameter int T1L      = 6,
    parameter int RES      = 500,
    localparam int AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [8*CHANNELS-1:0]   wr_data,
    input  logic [7:0]              brightness,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    ws_out
);

    // -----------------------------------------------------------------------
    // Derived sizes
    // -----------------------------------------------------------------------
    localparam int BITS   = 8 * CHANNELS;
    localparam int BW     = $clog2(BITS);
    localparam int TMAX_H = (T0H > T1H) ? T0H : T1H;
    localparam int TMAX_L = (T0L > T1L) ? T0L : T1L;
    localparam int TMAX_B = (TMAX_H > TMAX_L) ? TMAX_H : TMAX_L;
    localparam int TMAX   = (RES > TMAX_B) ? RES : TMAX_B;
    // The phase counter runs 0..duration-1, so it never has to hold TMAX.
    localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

    // A misconfigured instance never leaves IDLE rather than driving a
    // malformed waveform onto the chain.
    localparam bit CFG_OK = (CLK_FREQ > 0) && (NUM_LEDS >= 1) &&
                            ((CHANNELS == 3) || (CHANNELS == 4)) &&
                            (T0H >= 1) && (T0L >= 1) && (T1H >= 1) &&
                            (T1L >= 1) && (RES >= 1);

    localparam logic [TW-1:0] T0H_M1 = TW'(T0H - 1);
    localparam logic [TW-1:0] T0L_M1 = TW'(T0L - 1);
    localparam logic [TW-1:0] T1H_M1 = TW'(T1H - 1);
    localparam logic [TW-1:0] T1L_M1 = TW'(T1L - 1);
    localparam logic [TW-1:0] RES_M1 = TW'(RES - 1);

    localparam logic [BW-1:0] LAST_BIT  = BW'(BITS - 1);
    localparam logic [AW-1:0] LAST_PIX  = AW'(NUM_LEDS - 1);
    // One extra bit so the pixel count itself is representable.
    localparam logic [AW:0]   PIX_LIMIT = (AW + 1)'(NUM_LEDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_t;

    // -----------------------------------------------------------------------
    // Brightness scaling: each byte becomes (b * (br + 1)) >> 8, so 255 is a
    // pass-through and 0 blanks the pixel. 255 * 256 fits in 16 bits.
    // -----------------------------------------------------------------------
    function automatic logic [BITS-1:0] scale_pixel(
        input logic [BITS-1:0] pix,
        input logic [7:0]      br
    );
        logic [BITS-1:0] res;
        logic [15:0]     prod;
        res = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            prod = {8'd0, pix[i*8 +: 8]} * ({8'd0, br} + 16'd1);
            res[i*8 +: 8] = prod[15:8];
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Signals
    // -----------------------------------------------------------------------
    logic [BITS-1:0] r_mem [NUM_LEDS];

    state_t          r_state;
    state_t          w_state_next;
    logic [BITS-1:0] r_shift;       // current pixel, MSB is the bit on air
    logic [BITS-1:0] r_next_raw;    // prefetched, unscaled next pixel
    logic [7:0]      r_bright;      // brightness frozen for the frame
    logic [BW-1:0]   r_bit_cnt;
    logic [AW-1:0]   r_pix_cnt;
    logic [TW-1:0]   r_tcnt;        // cycles spent in the current phase
    logic            r_ws;
    logic            r_busy;
    logic            r_done;

    logic            w_wr_ok;
    logic            w_cur_bit;
    logic            w_last_bit;
    logic            w_last_pix;
    logic [AW-1:0]   w_next_idx;
    logic [TW-1:0]   w_dur_m1;
    logic            w_phase_end;

    assign w_wr_ok    = wr_en && ({1'b0, wr_addr} < PIX_LIMIT);
    assign w_cur_bit  = r_shift[BITS-1];
    assign w_last_bit = (r_bit_cnt == LAST_BIT);
    assign w_last_pix = (r_pix_cnt == LAST_PIX);
    // Only consulted while another pixel remains, so the wrap value is unused.
    assign w_next_idx = w_last_pix ? '0 : r_pix_cnt + AW'(1);

    // -----------------------------------------------------------------------
    // Frame buffer write port
    // -----------------------------------------------------------------------
    // NOTE: the frame buffer is plain storage with no reset branch, so it
    // maps onto RAM; after reset it simply keeps whatever was last written.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Phase length for the current state and bit value
    // -----------------------------------------------------------------------
    // NOTE: every variable written in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_dur_m1 = '0;
        unique case (r_state)
            S_HIGH:  w_dur_m1 = w_cur_bit ? T1H_M1 : T0H_M1;
            S_LOW:   w_dur_m1 = w_cur_bit ? T1L_M1 : T0L_M1;
            S_LATCH: w_dur_m1 = RES_M1;
            default: w_dur_m1 = '0;
        endcase
    end

    assign w_phase_end = (r_tcnt == w_dur_m1);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && CFG_OK) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_next = S_HIGH;
            end
            S_HIGH: begin
                if (w_phase_end) begin
                    w_state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (w_phase_end) begin
                    w_state_next = (w_last_bit && w_last_pix) ? S_LATCH : S_HIGH;
                end
            end
            S_LATCH: begin
                if (w_phase_end) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and datapath
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register here sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ws       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tcnt     <= '0;
            r_bit_cnt  <= '0;
            r_pix_cnt  <= '0;
            r_shift    <= '0;
            r_next_raw <= '0;
            r_bright   <= '0;
        end else begin
            r_state <= w_state_next;
            // Registering the decoded next state keeps ws_out glitch-free and
            // aligned with the state that owns each cycle.
            r_ws    <= (w_state_next == S_HIGH);
            r_done  <= 1'b0;

            if (w_phase_end) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + TW'(1);
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_state_next == S_LOAD) begin
                        r_busy   <= 1'b1;
                        r_bright <= brightness;
                    end
                end
                S_LOAD: begin
                    r_shift   <= scale_pixel(r_mem[0], r_bright);
                    r_bit_cnt <= '0;
                    r_pix_cnt <= '0;
                end
                S_HIGH: begin
                    // Fetch the following pixel while the last bit of this
                    // one is high, so the pixel boundary costs no cycle.
                    if (w_last_bit && !w_last_pix) begin
                        r_next_raw <= r_mem[w_next_idx];
                    end
                end
                S_LOW: begin
                    if (w_phase_end) begin
                        if (!w_last_bit) begin
                            r_shift   <= {r_shift[BITS-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end else if (!w_last_pix) begin
                            r_shift   <= scale_pixel(r_next_raw, r_bright);
                            r_bit_cnt <= '0;
                            r_pix_cnt <= r_pix_cnt + AW'(1);
                        end
                    end
                end
                S_LATCH: begin
                    if (w_phase_end) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ws_out = r_ws;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ws2812_chain_driver
//
// Directed sequence of frames with random pixel data and brightness. The
// expected serial waveform of each frame is rebuilt from the pixel values
// alone: scale each byte, then emit a high run and a low run per bit, then
// the latch gap.
// ---------------------------------------------------------------------------
module tb_ws2812_chain_driver;

    localparam int NUM_LEDS = 3;
    localparam int CHANNELS = 3;
    localparam int T0H      = 4;
    localparam int T0L      = 8;
    localparam int T1H      = 7;
    localparam int T1L      = 6;
    localparam int RES      = 500;
    localparam int AW       = 2;
    localparam int NBITS    = 24 * NUM_LEDS;
    localparam int LIMIT    = 4000;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [23:0]       wr_data;
    logic [7:0]        brightness;
    logic              start;
    logic              busy;
    logic              done;
    logic              ws_out;

    int                checks = 0;
    int                errors = 0;

    logic [23:0]       m_buf [NUM_LEDS];
    logic [NBITS-1:0]  last_stream;
    int                last_busy;
    int                bad_ws;
    int                bad_busy;
    int                n_done;
    int                len;

    ws2812_chain_driver #(
        .CLK_FREQ (10000000),
        .NUM_LEDS (NUM_LEDS),
        .CHANNELS (CHANNELS),
        .T0H      (T0H),
        .T0L      (T0L),
        .T1H      (T1H),
        .T1L      (T1L),
        .RES      (RES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .brightness (brightness),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .ws_out     (ws_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ----- reference model ---------------------------------------------------
    function automatic logic [23:0] scaled_pixel(input logic [23:0] p, input int br);
        logic [23:0] r;
        int          b;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            b = int'((p >> (8 * c)) & 24'hFF);
            r[8*c +: 8] = 8'((b * (br + 1)) / 256);
        end
        return r;
    endfunction

    function automatic logic [NBITS-1:0] model_stream(input int br);
        return {scaled_pixel(m_buf[0], br), scaled_pixel(m_buf[1], br),
                scaled_pixel(m_buf[2], br)};
    endfunction

    function automatic int pixel_len(input int p, input int br);
        logic [23:0] s;
        int          n;
        s = scaled_pixel(m_buf[p], br);
        n = 0;
        for (int i = 0; i < 24; i++) n += s[i] ? (T1H + T1L) : (T0H + T0L);
        return n;
    endfunction

    function automatic int frame_len(input int br);
        int n;
        n = 1 + RES;
        for (int p = 0; p < NUM_LEDS; p++) n += pixel_len(p, br);
        return n;
    endfunction

    // ----- stimulus helpers --------------------------------------------------
    task automatic write_pix(input logic [AW-1:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (int'(a) < NUM_LEDS) m_buf[a] = d;
    endtask

    // Starts a frame at the current negedge and follows it to done.
    // st_at / wr_at / rst_at: negedge index (1 = first after accept) at which
    // to pulse start, write pixel wa (and change brightness), or pulse rst.
    // watch: cycles to keep observing after done.
    task automatic run_frame(input string tag, input int st_at, input int wr_at,
                             input logic [AW-1:0] wa, input logic [23:0] wd,
                             input int rst_at, input int watch);
        int               br_acc;
        int               busy_cnt;
        int               done_cnt;
        int               extra_busy;
        int               mism;
        int               idx;
        int               h;
        bit               got_done;
        bit               obs_q[$];
        bit               exp_q[$];
        logic [NBITS-1:0] obs_s;
        logic [NBITS-1:0] exp_s;

        br_acc   = int'(brightness);
        busy_cnt = 0;
        done_cnt = 0;
        got_done = 1'b0;
        start    = 1'b1;
        for (int k = 1; k <= LIMIT && !got_done; k++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (rst) begin
                rst = 1'b0;
                check({tag, " ws_out after rst"}, 96'(ws_out), 96'(0));
                check({tag, " busy after rst"}, 96'(busy), 96'(0));
                check({tag, " done after rst"}, 96'(done), 96'(0));
                return;
            end
            if (done) begin
                done_cnt++;
                got_done = 1'b1;
            end else if (busy) begin
                busy_cnt++;
                obs_q.push_back(ws_out);
            end
            if (k == st_at) start = 1'b1;
            if (k == wr_at) begin
                wr_en      = 1'b1;
                wr_addr    = wa;
                wr_data    = wd;
                brightness = brightness ^ 8'h5A;
                if (int'(wa) < NUM_LEDS) m_buf[wa] = wd;
            end
            if (k == rst_at) rst = 1'b1;
        end
        if (!got_done) begin
            check({tag, " done within cycle budget"}, 96'(0), 96'(1));
            return;
        end

        extra_busy = 0;
        for (int j = 0; j < watch; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) extra_busy++;
            if (done) done_cnt++;
        end

        exp_s = model_stream(br_acc);
        exp_q.push_back(1'b0);
        for (int i = NBITS - 1; i >= 0; i--) begin
            repeat (exp_s[i] ? T1H : T0H) exp_q.push_back(1'b1);
            repeat (exp_s[i] ? T1L : T0L) exp_q.push_back(1'b0);
        end
        repeat (RES) exp_q.push_back(1'b0);

        mism = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] != exp_q[i]) mism++;

        idx   = 1;
        obs_s = '0;
        for (int n = NBITS - 1; n >= 0; n--) begin
            h = 0;
            while (idx < obs_q.size() && obs_q[idx]) begin h++; idx++; end
            while (idx < obs_q.size() && !obs_q[idx]) idx++;
            obs_s[n] = (h == T1H);
        end

        last_stream = obs_s;
        last_busy   = busy_cnt;
        check({tag, " busy cycles"}, 96'(busy_cnt), 96'(exp_q.size()));
        check({tag, " done pulses"}, 96'(done_cnt), 96'(1));
        check({tag, " waveform mismatching cycles"}, 96'(mism), 96'(0));
        check({tag, " decoded stream"}, 96'(obs_s), 96'(exp_s));
        if (watch > 0) check({tag, " busy after done"}, 96'(extra_busy), 96'(0));
    endtask

    // ----- directed sequence -------------------------------------------------
    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        brightness = 8'd255;
        start      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ws_out", 96'(ws_out), 96'(0));
        check("reset busy", 96'(busy), 96'(0));
        check("reset done", 96'(done), 96'(0));
        rst = 1'b0;

        bad_ws = 0; bad_busy = 0; n_done = 0;
        repeat (100) begin
            @(negedge clk);
            if (ws_out) bad_ws++;
            if (busy) bad_busy++;
            if (done) n_done++;
        end
        check("idle ws_out high cycles", 96'(bad_ws), 96'(0));
        check("idle busy cycles", 96'(bad_busy), 96'(0));
        check("idle done pulses", 96'(n_done), 96'(0));

        // All-zero frame: 72 pulses of 4 high / 8 low.
        for (int p = 0; p < NUM_LEDS; p++) write_pix(AW'(p), 24'h000000);
        brightness = 8'd255;
        run_frame("zero frame", -1, -1, '0, '0, -1, 20);
        check("zero frame busy length", 96'(last_busy), 96'(1 + 72 * 12 + 500));

        // Mixed pattern across a pixel boundary.
        write_pix(2'd0, 24'hFF00AA);
        write_pix(2'd1, 24'h800080);
        write_pix(2'd2, 24'($urandom));
        run_frame("pattern frame", -1, -1, '0, '0, -1, 20);
        check("pattern bits", 96'(last_stream[71:24]), 96'(48'hFF00AA800080));

        // Half brightness.
        write_pix(2'd0, 24'hFF8001);
        write_pix(2'd1, 24'($urandom));
        brightness = 8'd127;
        run_frame("half brightness", -1, -1, '0, '0, -1, 20);
        check("half brightness pixel 0", 96'(last_stream[71:48]), 96'(24'h7F4000));

        // Zero brightness blanks everything.
        write_pix(2'd2, 24'($urandom));
        brightness = 8'd0;
        run_frame("zero brightness", -1, -1, '0, '0, -1, 20);
        check("zero brightness stream", 96'(last_stream), 96'(0));

        // Start while busy is dropped; pixel 1 rewritten during pixel 0;
        // brightness changed mid-frame must not affect this frame.
        brightness = 8'($urandom_range(1, 254));
        run_frame("busy start and live write", 30, 40, 2'd1, 24'($urandom), -1, 20);

        // Out-of-range write must not disturb the buffer.
        write_pix(2'd3, 24'hFFFFFF);

        // Start in the last latch cycle is ignored; start right after done
        // is accepted (next frame begins on that very cycle).
        brightness = 8'($urandom_range(0, 255));
        len = frame_len(int'(brightness));
        run_frame("start on last latch cycle", len, -1, '0, '0, -1, 0);
        write_pix(2'd0, 24'($urandom));
        brightness = 8'($urandom_range(0, 255));
        run_frame("back to back frame", -1, -1, '0, '0, -1, 20);

        // Reset in the middle of pixel 1.
        brightness = 8'd255;
        write_pix(2'd0, 24'($urandom));
        write_pix(2'd1, 24'($urandom));
        write_pix(2'd2, 24'($urandom));
        len = 1 + pixel_len(0, int'(brightness)) + 40;
        run_frame("mid-frame reset", -1, -1, '0, '0, len, 0);
        bad_ws = 0; bad_busy = 0; n_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (ws_out) bad_ws++;
            if (busy) bad_busy++;
            if (done) n_done++;
        end
        check("after reset ws_out high cycles", 96'(bad_ws), 96'(0));
        check("after reset busy cycles", 96'(bad_busy), 96'(0));
        check("after reset done pulses", 96'(n_done), 96'(0));

        brightness = 8'($urandom_range(0, 255));
        run_frame("frame after reset", -1, -1, '0, '0, -1, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
